// File: rtl/sys_mem_arb_if.sv
// sys_mem_arb_if: one sys_mem command/return port.
// master issues commands; slave stalls them and returns read data.
interface sys_mem_arb_if #(
   parameter int SYS_MEM_DATA_W = 32,
   parameter int SYS_MEM_ADDR_W = 27
);
   logic                      wren;
   logic                      rden;
   logic [SYS_MEM_ADDR_W-1:0] addr;
   logic [SYS_MEM_DATA_W-1:0] wdata;
   logic                      waitreq;
   logic                      rd_valid;
   logic [SYS_MEM_DATA_W-1:0] rdata;

   modport master (
      output wren, rden, addr, wdata,
      input  waitreq, rd_valid, rdata
   );

   modport slave (
      input  wren, rden, addr, wdata,
      output waitreq, rd_valid, rdata
   );
endinterface

// File: rtl/sys_mem_arb.sv
// sys_mem_arb: two-requester sys_mem arbiter, zero-latency mux, tag FIFO.
// SYS_MEM_ARB_M0_PRIO_EN selects fixed m0 priority over round-robin.
module sys_mem_arb #(
   parameter int SYS_MEM_DATA_W = 32,
   parameter int SYS_MEM_ADDR_W = 27,
   parameter int RD_TAG_DEPTH   = 8
) (
   input  logic          clk,
   input  logic          rst,
   sys_mem_arb_if.slave  m0,
   sys_mem_arb_if.slave  m1,
   sys_mem_arb_if.master sys_mem,
   output logic          tag_err
);
   localparam int PW = $clog2(RD_TAG_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {ST_OPEN, ST_LOCK} lock_t;

   lock_t state, state_nx;
   logic  gnt, last, sel, tie_sel;
   logic  req0, req1;
   logic  sel_wr, sel_rd, rd_block;
   logic  cmd, accept, push, pop;
   logic  full, empty, head;

   logic [SYS_MEM_ADDR_W-1:0] sel_addr;
   logic [SYS_MEM_DATA_W-1:0] sel_wdata;
   logic [RD_TAG_DEPTH-1:0]   tags;
   logic [PW-1:0]             wr_ptr, rd_ptr;
   logic [CW-1:0]             count;

   assign req0 = m0.wren | m0.rden;
   assign req1 = m1.wren | m1.rden;

`ifdef SYS_MEM_ARB_M0_PRIO_EN
   assign tie_sel = 1'b0;
`else
   assign tie_sel = ~last;
`endif

   always_comb begin
      sel = gnt;
      if (state == ST_OPEN) begin
         unique case (1'b1)
            req0 & ~req1: sel = 1'b0;
            req1 & ~req0: sel = 1'b1;
            req0 & req1:  sel = tie_sel;
            default:      sel = gnt;
         endcase
      end
   end

   // A write beats a read from the same requester.
   assign sel_wr    = sel ? m1.wren : m0.wren;
   assign sel_rd    = (sel ? m1.rden : m0.rden) & ~sel_wr;
   assign sel_addr  = sel ? m1.addr : m0.addr;
   assign sel_wdata = sel ? m1.wdata : m0.wdata;

   assign full     = count == CW'(RD_TAG_DEPTH);
   assign empty    = count == '0;
   assign rd_block = full & sel_rd;

   assign sys_mem.wren  = sel_wr;
   assign sys_mem.rden  = sel_rd & ~rd_block;
   assign sys_mem.addr  = sel_addr;
   assign sys_mem.wdata = sel_wdata;

   assign cmd    = sys_mem.wren | sys_mem.rden;
   assign accept = cmd & ~sys_mem.waitreq;
   assign push   = sys_mem.rden & ~sys_mem.waitreq;
   assign pop    = sys_mem.rd_valid & ~empty;
   assign head   = tags[rd_ptr];

   assign m0.waitreq =
      sel ? req0 : (sys_mem.waitreq | rd_block);
   assign m1.waitreq =
      sel ? (sys_mem.waitreq | rd_block) : req1;

   assign m0.rd_valid = pop & ~head;
   assign m1.rd_valid = pop & head;
   assign m0.rdata    = sys_mem.rdata;
   assign m1.rdata    = sys_mem.rdata;

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_OPEN: if (cmd & sys_mem.waitreq) state_nx = ST_LOCK;
         ST_LOCK: if (accept | ~cmd) state_nx = ST_OPEN;
         default: state_nx = ST_OPEN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_OPEN;
         gnt   <= 1'b0;
         last  <= 1'b1;
      end else begin
         state <= state_nx;
         gnt   <= sel;
         if (accept) last <= sel;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tags    <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         tag_err <= 1'b0;
      end else begin
         if (push) begin
            tags[wr_ptr] <= sel;
            wr_ptr       <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop) count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
         if (sys_mem.rd_valid && empty) tag_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_sys_mem_arb.sv
// tb_sys_mem_arb: directed scenarios plus a randomized
// two-master / one-memory run checked through scoreboard queues.
`timescale 1ns/1ps
module tb_sys_mem_arb;
   localparam int DW    = 32;
   localparam int AW    = 27;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sys_mem_arb_if #(.SYS_MEM_DATA_W(DW), .SYS_MEM_ADDR_W(AW)) m0_if ();
   sys_mem_arb_if #(.SYS_MEM_DATA_W(DW), .SYS_MEM_ADDR_W(AW)) m1_if ();
   sys_mem_arb_if #(.SYS_MEM_DATA_W(DW), .SYS_MEM_ADDR_W(AW)) mem_if ();
   logic tag_err;

   sys_mem_arb #(
      .SYS_MEM_DATA_W(DW),
      .SYS_MEM_ADDR_W(AW),
      .RD_TAG_DEPTH  (DEPTH)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .m0     (m0_if),
      .m1     (m1_if),
      .sys_mem(mem_if),
      .tag_err(tag_err)
   );

   logic          r_wren [2];
   logic          r_rden [2];
   logic [AW-1:0] r_addr [2];
   logic [DW-1:0] r_wdata[2];
   logic          w_wait [2];
   logic          mem_wait, mem_rdv;
   logic [DW-1:0] mem_rdata;

   assign m0_if.wren  = r_wren[0];
   assign m0_if.rden  = r_rden[0];
   assign m0_if.addr  = r_addr[0];
   assign m0_if.wdata = r_wdata[0];
   assign m1_if.wren  = r_wren[1];
   assign m1_if.rden  = r_rden[1];
   assign m1_if.addr  = r_addr[1];
   assign m1_if.wdata = r_wdata[1];
   assign w_wait[0]   = m0_if.waitreq;
   assign w_wait[1]   = m1_if.waitreq;
   assign mem_if.waitreq  = mem_wait;
   assign mem_if.rd_valid = mem_rdv;
   assign mem_if.rdata    = mem_rdata;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int last_due    = 0;
   bit dev_en      = 1'b0;

   // reference model state and scoreboard queues
   logic [DW-1:0] ref_mem[int];
   logic [DW-1:0] dev_mem[int];
   logic [AW-1:0] exp_wr_a[$];
   logic [DW-1:0] exp_wr_d[$];
   logic [AW-1:0] exp_rd_a[$];
   logic [DW-1:0] exp_rd0[$];
   logic [DW-1:0] exp_rd1[$];
   logic [DW-1:0] ret_d[$];
   int            ret_due[$];

   function automatic void chk(input string nm,
                               input logic [63:0] act,
                               input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   function automatic logic [DW-1:0] init_val(input int a);
      return DW'(a) ^ 32'h5a5a_0000;
   endfunction

   task automatic clear_drives();
      for (int i = 0; i < 2; i++) begin
         r_wren[i]  = 1'b0;
         r_rden[i]  = 1'b0;
         r_addr[i]  = '0;
         r_wdata[i] = '0;
      end
      mem_wait  = 1'b0;
      mem_rdv   = 1'b0;
      mem_rdata = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      step();
      rst = 1'b1;
      clear_drives();
      step();
      rst = 1'b0;
   endtask

   // memory device: random stall, in-order returns after random latency
   always begin
      @(posedge clk);
      #1;
      cyc++;
      if (dev_en) begin
         mem_wait = ($urandom_range(0, 3) == 0);
         if (ret_d.size() > 0 && ret_due[0] <= cyc) begin
            mem_rdv   = 1'b1;
            mem_rdata = ret_d.pop_front();
            void'(ret_due.pop_front());
         end else begin
            mem_rdv   = 1'b0;
            mem_rdata = $urandom;
         end
      end
   end

   // monitor: pops expectations whenever the DUT presents something
   always begin
      logic [DW-1:0] d;
      int            lat;
      @(negedge clk);
      #2;
      if (dev_en) begin
         if (mem_if.wren && !mem_wait) begin
            dev_mem[int'(mem_if.addr)] = mem_if.wdata;
            if (exp_wr_a.size() == 0) begin
               chk("unexpected_wr", 1, 0);
            end else begin
               chk("wr_addr", mem_if.addr, exp_wr_a.pop_front());
               chk("wr_data", mem_if.wdata, exp_wr_d.pop_front());
            end
         end
         if (mem_if.rden && !mem_wait) begin
            chk("outstanding_lt_depth",
                (ret_d.size() + int'(mem_rdv)) < DEPTH, 1);
            d = dev_mem.exists(int'(mem_if.addr)) ?
                dev_mem[int'(mem_if.addr)] : init_val(int'(mem_if.addr));
            lat = $urandom_range(1, 10);
            last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            ret_d.push_back(d);
            ret_due.push_back(last_due);
            if (exp_rd_a.size() == 0) chk("unexpected_rd", 1, 0);
            else chk("rd_addr", mem_if.addr, exp_rd_a.pop_front());
         end
         if (m0_if.rd_valid) begin
            if (exp_rd0.size() == 0) chk("unexpected_m0_rdv", 1, 0);
            else chk("m0_rdata", m0_if.rdata, exp_rd0.pop_front());
         end
         if (m1_if.rd_valid) begin
            if (exp_rd1.size() == 0) chk("unexpected_m1_rdv", 1, 0);
            else chk("m1_rdata", m1_if.rdata, exp_rd1.pop_front());
         end
      end
   end

   task automatic run_req(input int n, input int ncmd, input int gmax);
      int            t;
      bit            done;
      bit            wr;
      int            a;
      logic [DW-1:0] d;
      for (int k = 0; k < ncmd; k++) begin
         repeat ($urandom_range(0, gmax)) step();
         wr = 1'($urandom_range(0, 1));
         a  = $urandom_range(0, 15);
         d  = $urandom;
         r_wren[n]  = wr;
         r_rden[n]  = ~wr;
         r_addr[n]  = AW'(a);
         r_wdata[n] = d;
         t    = 0;
         done = 1'b0;
         while (!done) begin
            @(negedge clk);
            if (!w_wait[n]) begin
               done = 1'b1;
               if (wr) begin
                  ref_mem[a] = d;
                  exp_wr_a.push_back(AW'(a));
                  exp_wr_d.push_back(d);
               end else begin
                  exp_rd_a.push_back(AW'(a));
                  d = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
                  if (n == 0) exp_rd0.push_back(d);
                  else exp_rd1.push_back(d);
               end
            end else if (++t > 400) begin
               chk($sformatf("m%0d_accept_timeout", n), t, 0);
               done = 1'b1;
            end
            step();
         end
         r_wren[n] = 1'b0;
         r_rden[n] = 1'b0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_g;
      int tags[3];
      int t;
      clear_drives();

      // reset state
      @(negedge clk);
      chk("rst_wren", mem_if.wren, 0);
      chk("rst_rden", mem_if.rden, 0);
      chk("rst_m0_rdv", m0_if.rd_valid, 0);
      chk("rst_m1_rdv", m1_if.rd_valid, 0);
      chk("rst_tag_err", tag_err, 0);
      chk("rst_m0_wait", w_wait[0], 0);
      chk("rst_m1_wait", w_wait[1], 0);
      step();
      rst = 1'b0;

      // single m0 read, return three cycles later
      apply_reset();
      r_rden[0] = 1'b1;
      r_addr[0] = AW'(27'h123);
      @(negedge clk);
      chk("t1_rden", mem_if.rden, 1);
      chk("t1_addr", mem_if.addr, 27'h123);
      chk("t1_m0_wait", w_wait[0], 0);
      step();
      r_rden[0] = 1'b0;
      step();
      step();
      mem_rdv   = 1'b1;
      mem_rdata = 32'hdead_beef;
      @(negedge clk);
      chk("t1_m0_rdv", m0_if.rd_valid, 1);
      chk("t1_m1_rdv", m1_if.rd_valid, 0);
      chk("t1_rdata", m0_if.rdata, 32'hdead_beef);
      step();
      mem_rdv = 1'b0;

      // continuous contention with writes
      apply_reset();
      r_wren  = '{1'b1, 1'b1};
      r_wdata = '{32'ha0, 32'hb1};
      for (int i = 0; i < 6; i++) begin
`ifdef SYS_MEM_ARB_M0_PRIO_EN
         exp_g = 0;
`else
         exp_g = i % 2;
`endif
         @(negedge clk);
         chk("t2_wdata", mem_if.wdata, exp_g ? 32'hb1 : 32'ha0);
         chk("t2_gnt_wait", w_wait[exp_g], 0);
         chk("t2_other_wait", w_wait[1-exp_g], 1);
         step();
      end
      clear_drives();

      // m1 write stalled, m0 arrives mid-stall
      apply_reset();
      r_wren[1]  = 1'b1;
      r_wdata[1] = 32'hc1;
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin
            r_wren[0]  = 1'b1;
            r_wdata[0] = 32'hc0;
         end
         mem_wait = (c < 4);
         @(negedge clk);
         chk("t3_wdata", mem_if.wdata, 32'hc1);
         chk("t3_m1_wait", w_wait[1], c < 4);
         chk("t3_m0_wait", w_wait[0], c >= 2);
         step();
      end
      r_wren[1] = 1'b0;
      @(negedge clk);
      chk("t3_m0_wren", mem_if.wren, 1);
      chk("t3_m0_wdata", mem_if.wdata, 32'hc0);
      chk("t3_m0_wait_rel", w_wait[0], 0);
      step();
      clear_drives();

      // tag FIFO full blocks reads, not writes
      apply_reset();
      r_rden[0] = 1'b1;
      r_addr[0] = AW'(40);
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         chk("t4_fill_rden", mem_if.rden, 1);
         step();
      end
      @(negedge clk);
      chk("t4_full_rden", mem_if.rden, 0);
      chk("t4_full_wait", w_wait[0], 1);
      step();
      r_wren[1]  = 1'b1;
      r_wdata[1] = 32'hd1;
      @(negedge clk);
`ifdef SYS_MEM_ARB_M0_PRIO_EN
      chk("t4_m1_wren", mem_if.wren, 0);
      chk("t4_m1_wait", w_wait[1], 1);
`else
      chk("t4_m1_wren", mem_if.wren, 1);
      chk("t4_m1_wdata", mem_if.wdata, 32'hd1);
      chk("t4_m1_wait", w_wait[1], 0);
`endif
      step();
      r_wren[1] = 1'b0;
      mem_rdv   = 1'b1;
      @(negedge clk);
      chk("t4_ret_m0_rdv", m0_if.rd_valid, 1);
      chk("t4_ret_rden", mem_if.rden, 0);
      step();
      mem_rdv = 1'b0;
      @(negedge clk);
      chk("t4_after_rden", mem_if.rden, 1);
      chk("t4_after_wait", w_wait[0], 0);
      step();
      clear_drives();

      // interleaved reads, in-order routing, tag_err
      apply_reset();
      tags = '{0, 1, 0};
      for (int k = 0; k < 3; k++) begin
         r_rden[tags[k]] = 1'b1;
         r_addr[tags[k]] = AW'(k + 1);
         @(negedge clk);
         chk("t5_rd_addr", mem_if.addr, k + 1);
         step();
         r_rden[tags[k]] = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
         mem_rdv   = 1'b1;
         mem_rdata = 32'h500 + k;
         @(negedge clk);
         chk("t5_m0_rdv", m0_if.rd_valid, tags[k] == 0);
         chk("t5_m1_rdv", m1_if.rd_valid, tags[k] == 1);
         chk("t5_rdata", m1_if.rdata, 32'h500 + k);
         step();
      end
      @(negedge clk);
      chk("t5_empty_m0_rdv", m0_if.rd_valid, 0);
      chk("t5_empty_m1_rdv", m1_if.rd_valid, 0);
      step();
      mem_rdv = 1'b0;
      @(negedge clk);
      chk("t5_tag_err", tag_err, 1);

      // reset flushes an outstanding read
      apply_reset();
      @(negedge clk);
      chk("t6_tag_err_clr", tag_err, 0);
      step();
      r_rden[0] = 1'b1;
      step();
      r_rden[0] = 1'b0;
      apply_reset();
      mem_rdv = 1'b1;
      @(negedge clk);
      chk("t6_flushed_rdv", m0_if.rd_valid, 0);
      step();
      mem_rdv = 1'b0;
      @(negedge clk);
      chk("t6_tag_err", tag_err, 1);

      // randomized traffic against the scoreboard
      apply_reset();
      dev_en = 1'b1;
      fork
         run_req(0, 150, 3);
         run_req(1, 150, 2);
      join
      t = 0;
      while ((exp_rd0.size() + exp_rd1.size() + ret_d.size()) > 0
             && t < 500) begin
         step();
         t++;
      end
      step();
      step();
      dev_en = 1'b0;
      chk("drain_rd0", exp_rd0.size(), 0);
      chk("drain_rd1", exp_rd1.size(), 0);
      chk("drain_wr", exp_wr_a.size(), 0);
      chk("drain_rda", exp_rd_a.size(), 0);
      @(negedge clk);
      chk("rand_tag_err", tag_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
